// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encodings and default sizes for the Booth multiplier
package mult_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/booth_step_unit.sv
// rtl/booth_step_unit.sv - one combinational radix-2 Booth add-and-shift step
module booth_step_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] prod,
    input  logic               helper,
    input  logic [WIDTH:0]     a_ext,
    input  logic [WIDTH:0]     neg_a_ext,
    output logic [2*WIDTH-1:0] prod_next,
    output logic               helper_next
);

    logic [WIDTH:0] upper_ext;
    logic [WIDTH:0] sum;

    always_comb begin
        upper_ext = {prod[2*WIDTH-1], prod[2*WIDTH-1:WIDTH]};
        case ({prod[0], helper})
            2'b01:   sum = upper_ext + a_ext;
            2'b10:   sum = upper_ext + neg_a_ext;
            default: sum = upper_ext;
        endcase
        // The extra sum bit becomes the new sign, so the shift stays exact on overflow.
        prod_next   = {sum, prod[WIDTH-1:1]};
        helper_next = prod[0];
    end

endmodule

// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - sequential signed Booth multiplier with start/abort control
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int ITERS = MULT_ITERS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(ITERS + 1);

    mult_state_t        state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               helper_q, helper_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH:0]     neg_a_q, neg_a_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;

    logic [WIDTH:0]     a_in_ext;
    logic [WIDTH:0]     neg_a_in_ext;
    logic [2*WIDTH-1:0] step_prod;
    logic               step_helper;

    // A is kept one bit wider so that negating the most-negative value is exact.
    assign a_in_ext     = {data_operandA[WIDTH-1], data_operandA};
    assign neg_a_in_ext = (WIDTH+1)'(0) - a_in_ext;

    booth_step_unit #(.WIDTH(WIDTH)) u_step (
        .prod        (prod_q),
        .helper      (helper_q),
        .a_ext       (a_q),
        .neg_a_ext   (neg_a_q),
        .prod_next   (step_prod),
        .helper_next (step_helper)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        prod_d   = prod_q;
        helper_d = helper_q;
        a_d      = a_q;
        neg_a_d  = neg_a_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        if (ctrl_MULT) begin
            a_d      = a_in_ext;
            neg_a_d  = neg_a_in_ext;
            prod_d   = {{WIDTH{1'b0}}, data_operandB};
            helper_d = 1'b0;
            count_d  = '0;
            state_d  = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    prod_d   = step_prod;
                    helper_d = step_helper;
                    count_d  = count_q + CW'(1);
                    if (count_q == CW'(ITERS - 1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    // Result is committed on leaving DONE so a same-cycle restart can suppress it.
                    result_d = prod_q[WIDTH-1:0];
                    exc_d    = (prod_q[2*WIDTH-1:WIDTH] != {WIDTH{prod_q[WIDTH-1]}});
                    rdy_d    = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            prod_q   <= '0;
            helper_q <= 1'b0;
            a_q      <= '0;
            neg_a_q  <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            prod_q   <= prod_d;
            helper_q <= helper_d;
            a_q      <= a_d;
            neg_a_q  <= neg_a_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = (state_q == RUN);

endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - self-checking bench for mult_sequencer
module tb_mult_sequencer;

    localparam int W = 32;
    localparam int N = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         ctrl_MULT = 1'b0;
    logic [W-1:0] data_operandA = '0;
    logic [W-1:0] data_operandB = '0;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    int checks = 0;
    int errors = 0;

    mult_sequencer #(.WIDTH(W), .ITERS(N)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: full-precision signed product, truncated, overflow when not sign-extendable.
    function automatic logic [W:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        logic                  ex;
        p  = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        ex = (p != {{W{p[W-1]}}, p[W-1:0]});
        return {ex, p[W-1:0]};
    endfunction

    int           edge_n = 0;
    int           start_edge = 0;
    bit           active = 0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [W-1:0] exp_result = '0;
    logic         exp_exc = 1'b0;
    logic         exp_rdy = 1'b0;
    logic         exp_busy = 1'b0;
    int           rdy_seen = 0;

    always @(posedge clock) begin
        logic [W:0] r;
        edge_n++;
        exp_rdy = 1'b0;
        if (!reset) begin
            active     = 0;
            exp_result = '0;
            exp_exc    = 1'b0;
        end else if (ctrl_MULT) begin
            active     = 1;
            start_edge = edge_n;
            m_a        = data_operandA;
            m_b        = data_operandB;
        end else if (active && edge_n == start_edge + N + 1) begin
            r          = ref_mult(m_a, m_b);
            exp_result = r[W-1:0];
            exp_exc    = r[W];
            exp_rdy    = 1'b1;
            active     = 0;
        end
        exp_busy = active && ((edge_n - start_edge) < N);
        #1;
        if (data_resultRDY === 1'b1) rdy_seen++;
        chk("cyc_rdy", {63'd0, data_resultRDY}, {63'd0, exp_rdy});
        chk("cyc_busy", {63'd0, busy}, {63'd0, exp_busy});
        chk("cyc_result", {32'd0, data_result}, {32'd0, exp_result});
        chk("cyc_exc", {63'd0, data_exception}, {63'd0, exp_exc});
    end

    task automatic pulse(input logic [W-1:0] a, input logic [W-1:0] b);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy(output int k, output int bc);
        k  = 1;
        bc = 0;
        while (data_resultRDY !== 1'b1 && k < 80) begin
            if (busy === 1'b1) bc++;
            @(negedge clock);
            k++;
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         exc;
    } vec_t;

    vec_t vecs[8] = '{
        '{32'h00000003, 32'h00000005, 32'h0000000F, 1'b0},
        '{32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFD6, 1'b0},
        '{32'h00010000, 32'h00010000, 32'h00000000, 1'b1},
        '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1},
        '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0},
        '{32'h80000000, 32'h80000000, 32'h00000000, 1'b1},
        '{32'h80000000, 32'h00000001, 32'h80000000, 1'b0},
        '{32'h7FFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b1}
    };

    initial begin
        int k, bc, seen0;
        #1;
        chk("reset_result", {32'd0, data_result}, 64'd0);
        chk("reset_exc", {63'd0, data_exception}, 64'd0);
        chk("reset_rdy", {63'd0, data_resultRDY}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        foreach (vecs[i]) begin
            pulse(vecs[i].a, vecs[i].b);
            wait_rdy(k, bc);
            chk("vec_latency", 64'(k), 64'd34);
            chk("vec_busy_cycles", 64'(bc), 64'd32);
            chk("vec_result", {32'd0, data_result}, {32'd0, vecs[i].res});
            chk("vec_exc", {63'd0, data_exception}, {63'd0, vecs[i].exc});
            repeat (2) @(negedge clock);
        end

        // Restart while running: only the second operation completes.
        seen0 = rdy_seen;
        pulse(32'd2, 32'd2);
        repeat (9) @(negedge clock);
        pulse(32'd4, 32'hFFFFFFFD);
        wait_rdy(k, bc);
        chk("abort_latency", 64'(k), 64'd34);
        chk("abort_result", {32'd0, data_result}, 64'h00000000FFFFFFF4);
        repeat (3) @(negedge clock);
        chk("abort_pulses", 64'(rdy_seen - seen0), 64'd1);

        // Restart in the DONE cycle wins over completion.
        seen0 = rdy_seen;
        pulse(32'd5, 32'd5);
        repeat (32) @(negedge clock);
        pulse(32'd6, 32'd7);
        wait_rdy(k, bc);
        chk("done_prio_latency", 64'(k), 64'd34);
        chk("done_prio_result", {32'd0, data_result}, 64'd42);
        repeat (3) @(negedge clock);
        chk("done_prio_pulses", 64'(rdy_seen - seen0), 64'd1);

        // Asynchronous reset mid-operation.
        pulse(32'd9, 32'd9);
        repeat (14) @(negedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("async_result", {32'd0, data_result}, 64'd0);
        chk("async_exc", {63'd0, data_exception}, 64'd0);
        chk("async_rdy", {63'd0, data_resultRDY}, 64'd0);
        chk("async_busy", {63'd0, busy}, 64'd0);
        seen0 = rdy_seen;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        pulse(32'd1, 32'd1);
        wait_rdy(k, bc);
        chk("post_reset_latency", 64'(k), 64'd34);
        chk("post_reset_result", {32'd0, data_result}, 64'd1);
        chk("post_reset_pulses", 64'(rdy_seen - seen0), 64'd1);

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width.
REQ-002 SHALL have parameter ITERS, default 32, number of Booth steps per multiply (equal to WIDTH).
REQ-003 SHALL have port clock, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ctrl_MULT, input, 1, start pulse sampled on the rising edge.
REQ-006 SHALL have port data_operandA, input, WIDTH, signed multiplicand, sampled only when ctrl_MULT=1.
REQ-007 SHALL have port data_operandB, input, WIDTH, signed multiplier, sampled only when ctrl_MULT=1.
REQ-008 SHALL have port data_result, output, WIDTH, low WIDTH bits of the signed product.
REQ-009 SHALL have port data_exception, output, 1, product not representable in WIDTH signed bits.
REQ-010 SHALL have port data_resultRDY, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port busy, output, 1, high while steps are in progress.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL accept ctrl_MULT=1 in any state with the following effects:
- latch A and a registered two's-complement negation of A;
- load prod = {0, B} and helper = 0;
- set count = 0;
- enter RUN;
- deassert data_resultRDY.
REQ-014 SHALL perform exactly one radix-2 Booth step per cycle in RUN, selected by {prod[0], helper}:
- 01: add A to the upper half;
- 10: add -A to the upper half;
- 00 or 11: no add.
REQ-015 SHALL then shift prod one bit arithmetically right, load helper with the pre-shift prod[0], and increment count.
REQ-016 SHALL compute the upper-half addition with WIDTH+1-bit sign extension, so that A = most-negative gives the exact product.
REQ-017 SHALL move from RUN to DONE on the step where count = ITERS-1; ITERS steps are executed in total.
REQ-018 SHALL on entering DONE register data_result = prod[WIDTH-1:0] and data_exception = (prod[2W-1:WIDTH] differs from a replication of prod[WIDTH-1]).
REQ-019 SHALL on entering DONE assert data_resultRDY for exactly one cycle, then go to IDLE.
REQ-020 SHALL give this latency: with ctrl_MULT sampled at edge E0, data_resultRDY is high in the cycle following edge E0+ITERS+1.
REQ-021 SHALL hold data_result and data_exception stable from DONE until the next ctrl_MULT completes.
REQ-022 SHALL drive busy = 1 in RUN only.
REQ-023 SHALL treat ctrl_MULT during RUN as an abort-and-restart:
- no data_resultRDY is produced for the aborted operation;
- the new operation completes with the REQ-020 latency.
REQ-024 SHALL give ctrl_MULT priority over the DONE transition when both occur in the same cycle; the result is not updated and no pulse is produced.
REQ-025 SHALL ignore operand inputs at all times other than a ctrl_MULT edge.

Reset
REQ-026 SHALL on reset=0, immediately and regardless of clock:
- go to IDLE;
- set count = 0, prod = 0, helper = 0;
- set data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0.
REQ-027 SHALL discard any in-flight multiply when reset is asserted mid-operation and produce no completion pulse for it.
REQ-028 SHALL accept ctrl_MULT on the first rising edge after reset deasserts.

Structure
REQ-029 SHALL place the FSM state encodings, the WIDTH default and the ITERS default in shared package mult_pkg.
REQ-030 SHALL instantiate one combinational sub-module, booth_step_unit, that computes one Booth step:
- inputs: prod, helper, A, negA;
- outputs: next prod, next helper.
REQ-031 SHALL keep the counter, FSM and all registers in mult_sequencer.

Verification
REQ-032 SHALL cover: A=3, B=5 -> data_result=0x0000000F, exception=0, data_resultRDY one cycle after edge E0+33, busy high for 32 cycles.
REQ-033 SHALL cover: A=-7 (0xFFFFFFF9), B=6 -> data_result=0xFFFFFFD6, exception=0.
REQ-034 SHALL cover: A=0x00010000, B=0x00010000 -> data_result=0x00000000, exception=1; and A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, exception=1.
REQ-035 SHALL cover: start A=2, B=2, then ctrl_MULT at E0+10 with A=4, B=-3 -> exactly one data_resultRDY, at (E0+10)+33, data_result=0xFFFFFFF4.
REQ-036 SHALL cover: reset=0 asserted at E0+15 of a running multiply -> all outputs 0 immediately, no data_resultRDY; a new A=1, B=1 after release -> data_result=1.
